// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the sequential-multiplier state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SUB  = 4'b0111;
  localparam logic [3:0] ALU_NAND = 4'b1000;
  localparam logic [3:0] ALU_EQ0  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;

  localparam int MUL_W = 16;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_STEP = 2'd1,
    MUL_DONE = 2'd2
  } mulState_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-and-add 16x16 multiplier (low 16 bits) that borrows a shared ALU
// through a request/grant handshake for every accumulate step.
// Optional feature: define ALU_MUL_SEQ_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits are all zero.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MUL_W-1:0]  opA,
  input  logic [MUL_W-1:0]  opB,
  output logic              busy,
  output logic              done,
  output logic [MUL_W-1:0]  product,
  output logic              alu_req,
  input  logic              alu_gnt,
  output logic [3:0]        aluOp,
  output logic [MUL_W-1:0]  aluA,
  output logic [MUL_W-1:0]  aluB,
  input  logic [MUL_W-1:0]  aluResult
);

  mulState_t        state, nextState;
  logic [MUL_W-1:0] acc, mcand, mplier;
  logic [3:0]       count;
  logic             startAcc, stepGo, lastStep;

  // start is only honoured outside STEP; a granted STEP cycle advances one bit
  assign startAcc = start && (state != MUL_STEP);
  assign stepGo   = (state == MUL_STEP) && alu_gnt;

`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
  // stop once the shifted multiplier would be empty (or after bit 15)
  assign lastStep = (count == 4'd15) || (mplier[MUL_W-1:1] == '0);
`else
  assign lastStep = (count == 4'd15);
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MUL_IDLE;
    else          state <= nextState;
  end

  // next-state and ALU/handshake outputs; everything idles at zero outside STEP
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    alu_req   = 1'b0;
    aluOp     = ALU_ADD;
    aluA      = '0;
    aluB      = '0;
    case (state)
      MUL_IDLE: if (start) nextState = MUL_STEP;
      MUL_STEP: begin
        busy    = 1'b1;
        alu_req = 1'b1;
        aluA    = acc;
        aluB    = mplier[0] ? mcand : '0;
        if (alu_gnt && lastStep) nextState = MUL_DONE;
      end
      MUL_DONE: begin
        done      = 1'b1;
        nextState = start ? MUL_STEP : MUL_IDLE;
      end
      default: nextState = MUL_IDLE;
    endcase
  end

  // datapath: load on accepted start, shift/accumulate on granted steps,
  // latch the result into product on the final step (held until next done)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else if (startAcc) begin
      acc     <= '0;
      mcand   <= opA;
      mplier  <= opB;
      count   <= '0;
    end else if (stepGo) begin
      acc     <= aluResult;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      count   <= count + 4'd1;
      if (lastStep) product <= aluResult;
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural shared ALU and a
// scoreboard of expected products. Honours ALU_MUL_SEQ_EARLY_EXIT_EN.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, start, alu_gnt;
  logic [15:0] opA, opB;
  logic        busy, done, alu_req;
  logic [15:0] product, aluA, aluB, aluResult;
  logic [3:0]  aluOp;

  int nPass = 0;
  int nChk  = 0;
  logic [15:0] sb[$];

  alu_mul_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .opA(opA), .opB(opB),
    .busy(busy), .done(done), .product(product),
    .alu_req(alu_req), .alu_gnt(alu_gnt),
    .aluOp(aluOp), .aluA(aluA), .aluB(aluB), .aluResult(aluResult)
  );

  always #5 clk = ~clk;

  // shared ALU model
  always_comb begin
    aluResult = 16'h0;
    case (aluOp)
      ALU_ADD: aluResult = aluA + aluB;
      ALU_OR:  aluResult = aluA | aluB;
      ALU_XOR: aluResult = aluA ^ aluB;
      ALU_AND: aluResult = aluA & aluB;
      ALU_SUB: aluResult = aluA - aluB;
      default: aluResult = 16'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChk++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // granted steps needed for multiplier b
  function automatic int nSteps(input logic [15:0] b);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    int n = 1;
    for (int i = 1; i < 16; i++) if (b[i]) n = i + 1;
    return n;
`else
    return 16;
`endif
  endfunction

  // call at a negedge; returns at the next negedge (cycle 1 of the operation)
  task automatic startNow(input logic [15:0] a, input logic [15:0] b);
    start = 1'b1; opA = a; opB = b;
    sb.push_back(a * b);
    @(negedge clk);
    start = 1'b0; opA = $urandom; opB = $urandom;
  endtask

  // walk cycles until done (bounded), then check latency, busy span and product
  task automatic waitDone(input string tag, input int cyc0, input int bc0,
                          input int expCyc, input int expBusy);
    int cyc = cyc0;
    int bc  = bc0;
    while (!done && cyc < 100) begin
      if (busy) bc++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_cyc"}, cyc, expCyc);
    chk({tag, "_busyCycles"}, bc, expBusy);
    chk({tag, "_busyAtDone"}, {31'b0, busy}, 32'd0);
    if (sb.size() > 0) chk({tag, "_product"}, product, {16'b0, sb.pop_front()});
    else chk({tag, "_scoreboard"}, 32'd0, 32'd1);
  endtask

  initial begin
    int rstCyc;
    reset_n = 1'b0; start = 1'b0; alu_gnt = 1'b1; opA = 16'h0; opB = 16'h0;

    // reset state
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_req",  {31'b0, alu_req}, 0);
    chk("rst_alu",  {aluOp, 12'b0, aluA ^ 16'h0}, 0);
    chk("rst_aluB", aluB, 0);
    chk("rst_product", product, 0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);

    // 3 * 5, continuous grant
    startNow(16'd3, 16'd5);
    waitDone("m3x5", 1, 0, nSteps(16'd5) + 1, nSteps(16'd5));
    @(negedge clk);
    chk("m3x5_donePulse", {31'b0, done}, 0);
    chk("m3x5_hold", product, 16'h000F);

    // wraparound
    startNow(16'hFFFF, 16'hFFFF);
    waitDone("mFFFF", 1, 0, nSteps(16'hFFFF) + 1, nSteps(16'hFFFF));
    @(negedge clk);

    // zero multiplier
    startNow(16'h1234, 16'h0);
    waitDone("mZero", 1, 0, nSteps(16'h0) + 1, nSteps(16'h0));
    @(negedge clk);

`ifndef ALU_MUL_SEQ_EARLY_EXIT_EN
    // 7 * 2 with grant withdrawn for 3 cycles at step 4
    startNow(16'd7, 16'd2);
    repeat (3) @(negedge clk);
    alu_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_req", {31'b0, alu_req}, 1);
      chk("stall_op",  aluOp, ALU_ADD);
      chk("stall_A",   aluA, 16'd14);
      chk("stall_B",   aluB, 16'd0);
      if (i < 3) @(negedge clk);
    end
    alu_gnt = 1'b1;
    waitDone("stall", 7, 6, 20, 19);
    @(negedge clk);
`endif

    // reset mid-operation, then a fresh operation
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    rstCyc = 4;
`else
    rstCyc = 8;
`endif
    startNow(16'd100, 16'd100);
    repeat (rstCyc - 1) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("midRst_busy", {31'b0, busy}, 0);
    chk("midRst_req",  {31'b0, alu_req}, 0);
    chk("midRst_alu",  {aluOp, 12'b0, aluA}, 0);
    chk("midRst_aluB", aluB, 0);
    chk("midRst_product", product, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midRst_noDone", {31'b0, done}, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    chk("postRst_idle", {31'b0, busy | done}, 0);
    startNow(16'd100, 16'd100);
    waitDone("m100", 1, 0, nSteps(16'd100) + 1, nSteps(16'd100));
    chk("m100_val", product, 16'h2710);
    @(negedge clk);

    // start during STEP is ignored; start in DONE chains straight into STEP
    startNow(16'd3, 16'd5);
    @(negedge clk);
    start = 1'b1; opA = 16'd9; opB = 16'd9;
    @(negedge clk);
    start = 1'b0;
    waitDone("ignStart", 3, 2, nSteps(16'd5) + 1, nSteps(16'd5));
    startNow(16'd6, 16'd7);
    chk("chain_busy", {31'b0, busy}, 1);
    chk("chain_done", {31'b0, done}, 0);
    chk("chain_req",  {31'b0, alu_req}, 1);
    waitDone("chain", 1, 0, nSteps(16'd7) + 1, nSteps(16'd7));
    chk("chain_val", product, 16'd42);
    @(negedge clk);
    chk("chain_idle", {31'b0, busy | done}, 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule
